// File: rtl/pid_pkg.sv
// Shared Q8.8 fixed-point constants and saturation helper for the PID controller.
package pid_pkg;

    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned Q_W       = 16;
    localparam logic signed [15:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q_MIN = 16'sh8000;

    // Callers sign-extend any narrower signed value to 64 bits before saturating.
    function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
        if (v > 64'(Q_MAX)) begin
            return Q_MAX;
        end else if (v < 64'(Q_MIN)) begin
            return Q_MIN;
        end
        return 16'(v);
    endfunction

endpackage

// File: rtl/pid_q88_mul.sv
// Signed Q8.8 multiply: full-precision product, floor-shifted back to Q8.8 in 32 bits.
module pid_q88_mul
    import pid_pkg::*;
#(
    parameter int unsigned B_W = 16
) (
    input  logic signed [15:0]    a,
    input  logic signed [B_W-1:0] b,
    output logic signed [31:0]    y
);

    localparam int unsigned PROD_W = 16 + B_W;

    logic signed [PROD_W-1:0] prod;

    assign prod = PROD_W'(a) * PROD_W'(b);
    assign y    = 32'(prod >>> FRAC_BITS);

endmodule

// File: rtl/pid_controller_core.sv
// Single-cycle Q8.8 PID controller with clamped integrator and saturated output.
module pid_controller_core
    import pid_pkg::*;
#(
    parameter int INT_LIMIT = 32767
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] setpoint,
    input  logic [15:0] feedback,
    input  logic [15:0] kp,
    input  logic [15:0] ki,
    input  logic [15:0] kd,
    output logic [15:0] pid_out
);

    localparam int unsigned SUM_W = 34;
    localparam logic signed [SUM_W-1:0] LIM_POS = SUM_W'(INT_LIMIT);
    localparam logic signed [SUM_W-1:0] LIM_NEG = -LIM_POS;

    logic signed [16:0]      err_wide;
    logic signed [15:0]      error;
    logic signed [15:0]      prev_error;
    logic signed [17:0]      err_diff;
    logic signed [31:0]      integral_acc;
    logic signed [31:0]      p_term;
    logic signed [31:0]      i_step;
    logic signed [31:0]      d_term;
    logic signed [SUM_W-1:0] acc_sum;
    logic signed [SUM_W-1:0] acc_next;
    logic signed [SUM_W-1:0] pid_sum;

    assign err_wide = 17'($signed(setpoint)) - 17'($signed(feedback));
    assign error    = sat16(64'(err_wide));
    assign err_diff = 18'(error) - 18'(prev_error);

    pid_q88_mul #(.B_W(16)) u_mul_p (.a($signed(kp)), .b(error),    .y(p_term));
    pid_q88_mul #(.B_W(16)) u_mul_i (.a($signed(ki)), .b(error),    .y(i_step));
    pid_q88_mul #(.B_W(18)) u_mul_d (.a($signed(kd)), .b(err_diff), .y(d_term));

    // Anti-windup: the integrator never leaves [-INT_LIMIT, INT_LIMIT].
    always_comb begin
        acc_sum  = SUM_W'(integral_acc) + SUM_W'(i_step);
        acc_next = acc_sum;
        if (acc_sum > LIM_POS) begin
            acc_next = LIM_POS;
        end else if (acc_sum < LIM_NEG) begin
            acc_next = LIM_NEG;
        end
    end

    assign pid_sum = SUM_W'(p_term) + acc_next + SUM_W'(d_term);

    // Disable clears all state so a re-enable starts with no history.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            pid_out      <= '0;
            integral_acc <= '0;
            prev_error   <= '0;
        end else begin
            pid_out      <= sat16(64'(pid_sum));
            integral_acc <= 32'(acc_next);
            prev_error   <= error;
        end
    end

endmodule

// File: tb/tb_pid_controller_core.sv
// Self-checking bench for pid_controller_core: directed vectors plus randomized model comparison.
module tb_pid_controller_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] setpoint;
    logic [15:0] feedback;
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] kd;
    logic [15:0] pid_out;

    pid_controller_core dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .setpoint(setpoint),
        .feedback(feedback),
        .kp      (kp),
        .ki      (ki),
        .kd      (kd),
        .pid_out (pid_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    longint m_acc  = 0;
    longint m_prev = 0;

    typedef struct {
        logic        en;
        logic [15:0] sp;
        logic [15:0] fb;
        logic [15:0] kp;
        logic [15:0] ki;
        logic [15:0] kd;
        logic [15:0] exp_out;
        int          exp_acc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference behaviour in plain 64-bit arithmetic; >>> on longint is floor division by 256.
    task automatic model_step(input bit r, input bit en, input logic [15:0] sp, input logic [15:0] fb,
                              input logic [15:0] gp, input logic [15:0] gi, input logic [15:0] gd,
                              output longint out);
        longint err, p, d;
        if (r || !en) begin
            m_acc  = 0;
            m_prev = 0;
            out    = 0;
        end else begin
            err    = clampl(longint'($signed(sp)) - longint'($signed(fb)), -32768, 32767);
            p      = (longint'($signed(gp)) * err) >>> 8;
            m_acc  = clampl(m_acc + ((longint'($signed(gi)) * err) >>> 8), -32767, 32767);
            d      = (longint'($signed(gd)) * (err - m_prev)) >>> 8;
            m_prev = err;
            out    = clampl(p + m_acc + d, -32768, 32767);
        end
    endtask

    function automatic logic [15:0] rand_gain();
        if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 1023)) - 16'd512;
        return 16'($urandom);
    endfunction

    initial begin
        longint exp_out;
        longint exp_acc;
        bit     r;

        rst = 1'b1; enable = 1'b1;
        setpoint = 16'h0500; feedback = 16'h0100;
        kp = 16'h0200; ki = 16'h0019; kd = 16'h000C;

        // Reset dominates enable with live inputs.
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("reset_out[%0d]", i), longint'($signed(pid_out)), 0);
            check($sformatf("reset_acc[%0d]", i), longint'(dut.integral_acc), 0);
        end
        rst = 1'b0;

        vecs[0] = '{1'b1, 16'h0500, 16'h0000, 16'h0200, 16'h0019, 16'h000C, 16'h0AB9, 125};
        vecs[1] = '{1'b1, 16'h0500, 16'h0000, 16'h0200, 16'h0019, 16'h000C, 16'h0AFA, 250};
        vecs[2] = '{1'b0, 16'h0500, 16'h0000, 16'h0200, 16'h0019, 16'h000C, 16'h0000, 0};
        vecs[3] = '{1'b1, 16'h0500, 16'h0000, 16'h0200, 16'h0019, 16'h000C, 16'h0AB9, 125};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
        vecs[5] = '{1'b1, 16'h7FFF, 16'h8000, 16'h0100, 16'h0000, 16'h0000, 16'h7FFF, 0};
        vecs[6] = '{1'b1, 16'h8000, 16'h7FFF, 16'h0100, 16'h0000, 16'h0000, 16'h8000, 0};
        vecs[7] = '{1'b0, 16'h8000, 16'h7FFF, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 0};

        for (int i = 0; i < 8; i++) begin
            enable = vecs[i].en; setpoint = vecs[i].sp; feedback = vecs[i].fb;
            kp = vecs[i].kp; ki = vecs[i].ki; kd = vecs[i].kd;
            tick();
            check($sformatf("vec_out[%0d]", i), longint'(pid_out), longint'(vecs[i].exp_out));
            check($sformatf("vec_acc[%0d]", i), longint'(dut.integral_acc), longint'(vecs[i].exp_acc));
        end

        // Windup: +1280 per edge until the integrator pins at 32767.
        enable = 1'b1; setpoint = 16'h0A00; feedback = 16'h0000;
        kp = 16'h0080; ki = 16'h0080; kd = 16'h0000;
        for (int n = 1; n <= 30; n++) begin
            tick();
            exp_acc = clampl(1280 * longint'(n), -32767, 32767);
            exp_out = clampl(1280 + exp_acc, -32768, 32767);
            check($sformatf("windup_acc[%0d]", n), longint'(dut.integral_acc), exp_acc);
            check($sformatf("windup_out[%0d]", n), longint'($signed(pid_out)), exp_out);
        end

        // Unwind from the clamp with the error reversed.
        setpoint = 16'hF600;
        for (int n = 1; n <= 30; n++) begin
            tick();
            exp_acc = clampl(32767 - 1280 * longint'(n), -32767, 32767);
            exp_out = clampl(exp_acc - 1280, -32768, 32767);
            check($sformatf("unwind_acc[%0d]", n), longint'(dut.integral_acc), exp_acc);
            check($sformatf("unwind_out[%0d]", n), longint'($signed(pid_out)), exp_out);
        end

        // Randomized comparison against the reference model, starting from reset.
        rst = 1'b1; enable = 1'b1;
        tick();
        model_step(1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, exp_out);
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r        = ($urandom_range(0, 29) == 0);
            rst      = r;
            enable   = ($urandom_range(0, 9) != 0);
            setpoint = 16'($urandom);
            feedback = ($urandom_range(0, 1) == 0) ? 16'($urandom) : setpoint + 16'($urandom_range(0, 511)) - 16'd256;
            kp       = rand_gain();
            ki       = rand_gain();
            kd       = rand_gain();
            tick();
            model_step(r, enable, setpoint, feedback, kp, ki, kd, exp_out);
            check($sformatf("rand_out[%0d]", i), longint'($signed(pid_out)), exp_out);
            check($sformatf("rand_acc[%0d]", i), longint'(dut.integral_acc), m_acc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
